// File: rtl/mmio_uart_tx.sv
// Bus-mapped 8N1 UART transmitter: TXDATA pushes into a small byte FIFO, STATUS reports fill/overflow/busy.
// Reads are combinational; writes never stall, and a byte pushed into a full FIFO is dropped unless a pop frees a slot on the same edge.
module mmio_uart_tx #(
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter int         CLK_DIV    = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iBUS_CE,
  input  logic        iBUS_RD,
  input  logic        iBUS_WR,
  input  logic [7:0]  iBUS_ADDR,
  input  logic [31:0] iBUS_DATA,
  output logic [31:0] oBUS_DATA,
  output logic        oBUS_SEL,
  output logic        oTX
);
  localparam int             PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int             BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [PW-1:0]  PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]     DEPTH     = 4'(FIFO_DEPTH);
  localparam logic [7:0]     STAT_ADDR = BASE_ADDR + 8'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift, shift_nx;
  logic            tx_nx;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      count;
  logic            overflow;

  logic hit, hit_data, hit_stat, push, pop, accept, full, busy, baud_end, fifo_nonempty;
  logic bus_data_unused;

  assign hit_data = iBUS_CE && (iBUS_ADDR == BASE_ADDR);
  assign hit_stat = iBUS_CE && (iBUS_ADDR == STAT_ADDR);
  assign hit      = hit_data || hit_stat;
  assign oBUS_SEL = hit;

  assign full          = (count == DEPTH);
  assign fifo_nonempty = (count != 4'd0);
  assign busy          = (state != IDLE) || fifo_nonempty;
  assign baud_end      = (baud == BAUD_LAST);

  assign push   = hit_data && iBUS_WR;
  assign pop    = fifo_nonempty && ((state == IDLE) || ((state == STOP) && baud_end));
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || pop);

  assign oBUS_DATA = (hit_stat && iBUS_RD) ? {26'b0, count[2:0], overflow, full, busy} : 32'b0;
  assign bus_data_unused = ^{iBUS_DATA[31:8]};

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fifo_nonempty) state_nx = START;
      START:   if (baud_end) state_nx = DATA;
      DATA:    if (baud_end && (bit_cnt == 3'd7)) state_nx = STOP;
      STOP:    if (baud_end) state_nx = fifo_nonempty ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    shift_nx = shift;
    if (pop)                              shift_nx = mem[rd_ptr];
    else if ((state == DATA) && baud_end) shift_nx = {1'b0, shift[7:1]};
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oTX     <= 1'b1;
      baud    <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
    end else begin
      oTX   <= tx_nx;
      shift <= shift_nx;
      baud  <= ((state == IDLE) || baud_end) ? '0 : baud + 1'b1;
      if (state != DATA)  bit_cnt <= 3'd0;
      else if (baud_end)  bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (accept) mem[wr_ptr] <= iBUS_DATA[7:0];
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (push && !accept)                          overflow <= 1'b1;
      else if (hit_stat && iBUS_WR && iBUS_DATA[2]) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: written bytes queue expected frames, a line monitor decodes oTX and compares.
module tb_mmio_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        ce = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        sel, tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovf_n = 0;
  bit mon_en = 1'b0;
  bit mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  int start_q[$];

  mmio_uart_tx #(.BASE_ADDR(8'hF0), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iBUS_CE(ce), .iBUS_RD(rd), .iBUS_WR(wr),
    .iBUS_ADDR(addr), .iBUS_DATA(wdata), .oBUS_DATA(rdata), .oBUS_SEL(sel), .oTX(tx)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, output int n);
    ce = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
    @(negedge iCLK);
    ce = 1'b0; wr = 1'b0;
    n = cyc;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic s);
    ce = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = rdata; s = sel;
    ce = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge iCLK);
  endtask

  initial begin : line_monitor
    logic [FRAME-1:0] pat, exp_pat;
    logic [7:0] b;
    forever begin
      @(negedge iCLK);
      if (mon_en && tx === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        pat[0] = tx;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge iCLK);
          pat[i] = tx;
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected got=%h required=no_frame", pat);
        end else begin
          b = exp_q.pop_front();
          for (int i = 0; i < FRAME; i++)
            exp_pat[i] = (i < CLK_DIV) ? 1'b0 : (i >= 9 * CLK_DIV) ? 1'b1 : b[i / CLK_DIV - 1];
          if (pat !== exp_pat) begin
            failures++;
            $display("FAIL frame_bits byte=%h got=%h required=%h", b, pat, exp_pat);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic test_reset;
    logic [31:0] d; logic s;
    iRST = 1'b1;
    #2 iRST = 1'b0;
    @(negedge iCLK); @(negedge iCLK);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b required=1", tx); end
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b1) begin failures++; $display("FAIL reset_status got=%h sel=%b required=0 sel=1", d, s); end
    bus_read(8'h10, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b0) begin failures++; $display("FAIL miss_addr got=%h sel=%b required=0 sel=0", d, s); end
    @(negedge iCLK);
    iRST = 1'b1;
    mon_en = 1'b1;
    @(negedge iCLK);
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL post_reset_status got=%h required=0", d); end
  endtask

  task automatic test_single;
    int n; logic [31:0] d; logic s;
    start_q.delete();
    exp_q.push_back(8'h55);
    bus_write(8'hF0, 32'h0000_0055, n);
    wait_cyc(n + 2);
    bus_read(8'hF0, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b1) begin failures++; $display("FAIL txdata_read got=%h sel=%b required=0 sel=1", d, s); end
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL single_busy got=%h required=1", d); end
    wait_cyc(n + 40);
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL busy_before_stop_end got=%h required=1", d); end
    wait_cyc(n + 41);
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL single_idle got=%h required=0", d); end
    checks++;
    if (start_q.size() != 1 || start_q[0] != n + 1)
      begin failures++; $display("FAIL single_start frames=%0d start=%0d required=1 frame at %0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, n + 1); end
  endtask

  task automatic test_back_to_back;
    int n1, n2; logic [31:0] d; logic s;
    start_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    bus_write(8'hF0, 32'h0000_00A5, n1);
    bus_write(8'hF0, 32'h0000_003C, n2);
    wait_cyc(n1 + 2 * FRAME + 2);
    checks++;
    if (start_q.size() != 2 || start_q[0] != n1 + 1 || start_q[1] != n1 + 1 + FRAME)
      begin failures++; $display("FAIL b2b_starts frames=%0d required=2 starts at %0d,%0d", start_q.size(), n1 + 1, n1 + 1 + FRAME); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain left=%0d required=0", exp_q.size()); end
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL b2b_idle got=%h required=0", d); end
  endtask

  task automatic test_overflow;
    int n, m; logic [31:0] d; logic s;
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    start_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(bytes[i]);
    for (int i = 0; i < 6; i++) begin
      bus_write(8'hF0, {24'h0, bytes[i]}, m);
      if (i == 0) n = m;
    end
    ovf_n = n;
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h27) begin failures++; $display("FAIL overflow_status got=%h required=27", d); end
    bus_write(8'hF1, 32'h0000_0004, m);
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h23) begin failures++; $display("FAIL overflow_clear got=%h required=23", d); end
  endtask

  task automatic test_full_pop_push;
    int n; logic [31:0] d; logic s; bit gaps_ok;
    exp_q.push_back(8'h77);
    wait_cyc(ovf_n + FRAME);
    bus_write(8'hF0, 32'h0000_0077, n);
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h23) begin failures++; $display("FAIL full_pop_push got=%h required=23", d); end
    wait_cyc(ovf_n + 6 * FRAME + 4);
    checks++;
    if (exp_q.size() != 0 || mon_busy) begin failures++; $display("FAIL full_drain left=%0d required=0", exp_q.size()); end
    gaps_ok = (start_q.size() == 6) && (start_q[0] == ovf_n + 1);
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] != start_q[i-1] + FRAME) gaps_ok = 1'b0;
    checks++;
    if (!gaps_ok) begin failures++; $display("FAIL full_frame_spacing frames=%0d required=6 frames %0d cycles apart", start_q.size(), FRAME); end
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL full_idle got=%h required=0", d); end
  endtask

  task automatic test_reset_midframe;
    int n, lows; logic [31:0] d; logic s;
    mon_en = 1'b0;
    bus_write(8'hF0, 32'h0000_0055, n);
    wait_cyc(n + 1 + 4 * CLK_DIV + 1);
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL midframe_bit3 got=%b required=0", tx); end
    iRST = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_abort_tx got=%b required=1", tx); end
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_abort_status got=%h required=0", d); end
    @(negedge iCLK);
    iRST = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge iCLK);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL reset_no_frame low_cycles=%0d required=0", lows); end
    bus_read(8'hF1, d, s);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_after_status got=%h required=0", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
